// File: rtl/fir_tap6_coef_if.sv
// Stream and coefficient-register bundle for fir_tap6_coef.
// master: sample/coefficient source; slave: the filter.
interface fir_tap6_coef_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 36
);
  logic [31:0]              coef_b0b1;
  logic [31:0]              coef_b2b3;
  logic [31:0]              coef_b4b5;
  logic                     coef_load;
  logic                     sync_in;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_sync;
  logic                     coef_pending;
  logic                     coef_applied;

  modport master (
    output coef_b0b1, coef_b2b3, coef_b4b5, coef_load, sync_in, in_valid, in_data,
    input  out_valid, out_data, out_sync, coef_pending, coef_applied
  );

  modport slave (
    input  coef_b0b1, coef_b2b3, coef_b4b5, coef_load, sync_in, in_valid, in_data,
    output out_valid, out_data, out_sync, coef_pending, coef_applied
  );
endinterface

// File: rtl/fir_tap6_coef.sv
// 6-tap FIR with shadow/active coefficient sets swapped only on a frame sync.
// Optional macro FIR_SYNC_CLEAR_EN: zero the delay line when a new set is applied.
module fir_tap6_coef #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned ACC_W  = 36
) (
  input logic             user_clk,
  input logic             user_rst,
  fir_tap6_coef_if.slave  bus
);
  localparam int unsigned ProdW = DATA_W + COEF_W;
  localparam int unsigned PairW = ProdW + 1;

  logic [31:0]              shadow_q [3];
  logic                     pending_q, pending_d;
  logic                     applied_q;
  logic signed [COEF_W-1:0] coef_q [6];
  logic signed [DATA_W-1:0] x_q [5];
  logic signed [DATA_W-1:0] win [6];
  logic signed [ProdW-1:0]  prod_q [6];
  logic signed [PairW-1:0]  pair_q [3];
  logic signed [ACC_W-1:0]  acc_q;
  logic [2:0]               vld_q;
  logic [2:0]               sync_q;
  logic                     apply;

  // A load in the sync cycle wins: the fresh words must wait for the next sync.
  assign apply = bus.sync_in & pending_q & ~bus.coef_load;

  always_comb begin
    pending_d = pending_q;
    if (bus.coef_load) begin
      pending_d = 1'b1;
    end else if (apply) begin
      pending_d = 1'b0;
    end
  end

  always_comb begin
    win[0] = bus.in_data;
    for (int k = 1; k < 6; k++) begin
      win[k] = x_q[k-1];
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      for (int w = 0; w < 3; w++) shadow_q[w] <= '0;
      for (int k = 0; k < 6; k++) coef_q[k] <= '0;
      for (int k = 0; k < 5; k++) x_q[k] <= '0;
      for (int k = 0; k < 6; k++) prod_q[k] <= '0;
      for (int p = 0; p < 3; p++) pair_q[p] <= '0;
      acc_q     <= '0;
      vld_q     <= '0;
      sync_q    <= '0;
      pending_q <= 1'b0;
      applied_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      applied_q <= apply;
      if (bus.coef_load) begin
        shadow_q[0] <= bus.coef_b0b1;
        shadow_q[1] <= bus.coef_b2b3;
        shadow_q[2] <= bus.coef_b4b5;
      end
      if (apply) begin
        for (int w = 0; w < 3; w++) begin
          coef_q[2*w]   <= $signed(shadow_q[w][16 +: COEF_W]);
          coef_q[2*w+1] <= $signed(shadow_q[w][0 +: COEF_W]);
        end
      end

      if (bus.in_valid) begin
        for (int k = 0; k < 5; k++) x_q[k] <= win[k];
      end
`ifdef FIR_SYNC_CLEAR_EN
      if (apply) begin
        for (int k = 0; k < 5; k++) x_q[k] <= '0;
      end
`endif

      vld_q  <= {vld_q[1:0], bus.in_valid};
      sync_q <= {sync_q[1:0], bus.sync_in};

      // Each stage only updates under its own valid so out_data holds across gaps.
      if (bus.in_valid) begin
        for (int k = 0; k < 6; k++) begin
          prod_q[k] <= ProdW'(win[k]) * ProdW'(coef_q[k]);
        end
      end
      if (vld_q[0]) begin
        for (int p = 0; p < 3; p++) begin
          pair_q[p] <= PairW'(prod_q[2*p]) + PairW'(prod_q[2*p+1]);
        end
      end
      if (vld_q[1]) begin
        acc_q <= ACC_W'(pair_q[0]) + ACC_W'(pair_q[1]) + ACC_W'(pair_q[2]);
      end
    end
  end

  assign bus.out_valid    = vld_q[2];
  assign bus.out_data     = acc_q;
  assign bus.out_sync     = sync_q[2];
  assign bus.coef_pending = pending_q;
  assign bus.coef_applied = applied_q;
endmodule

// File: doc/fir_tap6_coef.md
FIR_TAP6_COEF -- requirements
Module: fir_tap6_coef

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed input sample width.
REQ-002 SHALL have parameter COEF_W, default 16: signed coefficient width; each 32-bit coefficient word carries two coefficients.
REQ-003 SHALL have parameter ACC_W, default 36: signed output width; must be at least DATA_W+COEF_W+3.
REQ-004 SHALL have one clock and a synchronous, active-high reset; port user_clk, input, 1 bit: sole clock, all logic on its rising edge.
REQ-005 SHALL have port user_rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port coef_b0b1, input, 32 bits: [31:16]=b0, [15:0]=b1, driven from the software-register user_data_out.
REQ-007 SHALL have port coef_b2b3, input, 32 bits: [31:16]=b2, [15:0]=b3.
REQ-008 SHALL have port coef_b4b5, input, 32 bits: [31:16]=b4, [15:0]=b5.
REQ-009 SHALL have port coef_load, input, 1 bit: capture all three coefficient words into the shadow set.
REQ-010 SHALL have port sync_in, input, 1 bit: frame boundary; the only point at which the shadow set becomes active.
REQ-011 SHALL have port in_valid, input, 1 bit: qualifies in_data.
REQ-012 SHALL have port in_data, input, DATA_W bits, signed sample.
REQ-013 SHALL have port out_valid, output, 1 bit, and port out_data, output, ACC_W bits signed: filtered sample.
REQ-014 SHALL have port out_sync, output, 1 bit: sync_in delayed to align with out_data.
REQ-015 SHALL have port coef_pending, output, 1 bit: shadow set captured but not yet applied.
REQ-016 SHALL have port coef_applied, output, 1 bit: one-cycle pulse in the cycle after the shadow set is applied.

Function
REQ-017 SHALL compute y[n] = sum over k=0..5 of b_k*x[n-k], with x the accepted-sample stream; the delay line shifts only when in_valid=1.
REQ-018 SHALL use full-precision signed multiply and sum, sign-extended to ACC_W, with no rounding or saturation.
REQ-019 SHALL use a fixed three-stage pipeline (products, pairwise sums, final sum): out_valid, out_data and out_sync are in_valid, the result and sync_in delayed by exactly 3 cycles; gaps in in_valid are preserved.
REQ-020 SHALL hold out_data at its last value while out_valid=0.
REQ-021 SHALL, on coef_load=1, register the three words into shadow and set coef_pending=1 the next cycle; a repeated coef_load overwrites shadow and pending stays 1.
REQ-022 SHALL, on sync_in=1 with coef_pending=1 (at the start of the cycle) and coef_load=0, copy shadow to active, clear coef_pending, and pulse coef_applied the next cycle.
REQ-023 SHALL, on sync_in=1 with coef_load=1 in the same cycle, capture the new words into shadow without applying them; coef_pending ends at 1.
REQ-024 SHALL, on sync_in=1 with coef_pending=0, leave the active coefficients unchanged and not pulse coef_applied.
REQ-025 SHALL compute a sample accepted in the apply cycle with the old set and samples from the next cycle onward with the new set; no output mixes the two sets within one product stage.

Reset
REQ-026 SHALL, on user_rst=1, clear the delay line, shadow and active coefficients and all pipeline registers, and drive out_valid=0, out_data=0, out_sync=0, coef_pending=0 and coef_applied=0 from the next cycle.
REQ-027 SHALL discard any in-flight samples and any pending coefficients when reset is asserted mid-operation; reset has priority over coef_load, sync_in and in_valid.

Configuration
REQ-028 SHALL, with macro FIR_SYNC_CLEAR_EN defined, zero the delay line in the same cycle the shadow set is applied (REQ-022), so that post-apply outputs contain no old-coefficient history.
REQ-029 SHALL, without FIR_SYNC_CLEAR_EN, retain delay line contents across a coefficient apply.

Verification
REQ-030 Impulse: load b0..b5=1,2,3,4,5,6, coef_load, then sync_in, then in_data 1 followed by five 0s, all valid -> out_data 1,2,3,4,5,6, each 3 cycles after input.
REQ-031 Pending: coef_load, then 10 cycles with no sync -> coef_pending=1 and outputs use the old set; sync_in -> coef_applied pulses once, coef_pending=0.
REQ-032 Simultaneous: coef_load and sync_in in the same cycle with pending=0 -> no apply and coef_pending=1; the next sync_in applies.
REQ-033 Extremes: all coefficients and samples=-32768 -> steady-state out_data=+6442450944 with no overflow.
REQ-034 Gaps/reset: alternate in_valid 1/0 -> out_valid shows the same pattern delayed by 3; assert user_rst mid-stream -> all outputs 0 the next cycle and the first post-reset output uses zero coefficients (out_data=0).
REQ-035 Build with and without FIR_SYNC_CLEAR_EN: apply a new set mid-stream of constant in_data=1 -> cleared build outputs partial sums ramping up under the new set; non-cleared build outputs the full new-set sum immediately.
